// File: rtl/memory_access_arbiter.sv
// Round-robin arbiter that serialises instruction fetches and loads/stores onto
// a single Avalon-style memory port, with registered bus outputs and a stall watchdog.
module memory_access_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ack,
  input  logic        data_req,
  input  logic        data_write,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_byteenable,
  input  logic [31:0] data_writedata,
  output logic        data_ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_e;
  typedef enum logic {G_FETCH, G_DATA} grant_e;

  localparam int unsigned    CW  = (TIMEOUT != 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]  TMO = CW'(TIMEOUT);

  state_e        state_q, state_d;
  grant_e        grant_q, grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   address_q, address_d;
  logic          read_q, read_d;
  logic          write_q, write_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          fack_q, fack_d;
  logic          dack_q, dack_d;
  logic          err_q, err_d;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    address_d = address_q;
    read_d    = read_q;
    write_d   = write_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    fack_d    = 1'b0;
    dack_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fetch_req || data_req) begin
          if (fetch_req && (!data_req || grant_q == G_DATA)) begin
            grant_d   = G_FETCH;
            address_d = {fetch_addr[31:2], 2'b00};
            read_d    = 1'b1;
            write_d   = 1'b0;
            be_d      = '1;
            wdata_d   = '0;
          end else begin
            grant_d   = G_DATA;
            address_d = {data_addr[31:2], 2'b00};
            read_d    = ~data_write;
            write_d   = data_write;
            be_d      = data_byteenable;
            wdata_d   = data_writedata;
          end
          cnt_d   = '0;
          state_d = S_BUS;
        end
      end

      S_BUS: begin
        // The strobes drop at the end of the last permitted stall; the abort
        // (ack with err) completes one cycle later so the ack lands at N+2+TIMEOUT.
        if (TIMEOUT != 0 && cnt_q == TMO) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          rdata_d = '0;
          err_d   = 1'b1;
          fack_d  = (grant_q == G_FETCH);
          dack_d  = (grant_q == G_DATA);
          state_d = S_DONE;
        end else if (!waitrequest) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          if (read_q) rdata_d = readdata;
          fack_d  = (grant_q == G_FETCH);
          dack_d  = (grant_q == G_DATA);
          state_d = S_DONE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == TMO) begin
            read_d  = 1'b0;
            write_d = 1'b0;
          end
        end
      end

      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= G_DATA;
      cnt_q     <= '0;
      address_q <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      fack_q    <= 1'b0;
      dack_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      address_q <= address_d;
      read_q    <= read_d;
      write_q   <= write_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      fack_q    <= fack_d;
      dack_q    <= dack_d;
      err_q     <= err_d;
    end
  end

  assign fetch_ack  = fack_q;
  assign data_ack   = dack_q;
  assign rdata      = rdata_q;
  assign err        = err_q;
  assign busy       = (state_q != S_IDLE);
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign byteenable = be_q;
  assign writedata  = wdata_q;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Bench for memory_access_arbiter: directed vector table, reset-mid-transfer
// sequence, then randomized transfers checked against a transaction-level model.
module tb_memory_access_arbiter;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req, data_req, data_write;
  logic [31:0] fetch_addr, data_addr, data_writedata;
  logic [3:0]  data_byteenable;
  logic        fetch_ack, data_ack, err, busy, read, write;
  logic [31:0] rdata, address, writedata, readdata;
  logic [3:0]  byteenable;
  logic        waitrequest;

  memory_access_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .data_req(data_req), .data_write(data_write), .data_addr(data_addr),
    .data_byteenable(data_byteenable), .data_writedata(data_writedata),
    .data_ack(data_ack), .rdata(rdata), .err(err), .busy(busy),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic        m_last_fetch;
  logic [31:0] m_rdata;

  typedef struct {
    logic        fr, dr, dw;
    logic [31:0] fa, da;
    logic [3:0]  be;
    logic [31:0] wd, rd;
    int unsigned waits;
    logic        exp_fetch;
    logic [31:0] exp_addr;
    logic        exp_rd, exp_wr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [8];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_strobe"}, read | write, 1'b0);
    chk1({tag, "_ack"}, fetch_ack | data_ack, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    @(posedge clk); #1;
  endtask

  // Drives one transfer starting in an IDLE cycle N; returns at cycle ack+1 (+1ns).
  task automatic run(input vec_t v);
    logic        tmo, strobe;
    int unsigned last;
    tmo  = (v.waits >= TMO);
    last = tmo ? TMO + 2 : v.waits + 2;
    fetch_req = v.fr; data_req = v.dr; data_write = v.dw;
    fetch_addr = v.fa; data_addr = v.da;
    data_byteenable = v.be; data_writedata = v.wd;
    waitrequest = 1'b0; readdata = $urandom;
    @(negedge clk);
    chk1("idle_busy", busy, 1'b0);
    chk32("idle_rdata", rdata, m_rdata);
    for (int unsigned c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      waitrequest = (c <= v.waits);
      readdata    = (!tmo && c == v.waits + 1) ? v.rd : $urandom;
      @(negedge clk);
      strobe = tmo ? (c <= TMO) : (c <= v.waits + 1);
      chk1("busy", busy, 1'b1);
      chk1("read", read, strobe & v.exp_rd);
      chk1("write", write, strobe & v.exp_wr);
      if (strobe) begin
        chk32("address", address, v.exp_addr);
        chk32("byteenable", {28'd0, byteenable}, {28'd0, v.exp_be});
        chk32("writedata", writedata, v.exp_wd);
      end
      chk1("fetch_ack", fetch_ack, (c == last) && v.exp_fetch);
      chk1("data_ack", data_ack, (c == last) && !v.exp_fetch);
      if (c == last) begin
        chk1("err", err, v.exp_err);
        chk32("rdata", rdata, v.exp_rdata);
      end else begin
        chk1("err_early", err, 1'b0);
      end
    end
    @(posedge clk); #1;
    fetch_req = 1'b0; data_req = 1'b0;
    m_rdata      = v.exp_rdata;
    m_last_fetch = v.exp_fetch;
  endtask

  // Transaction-level model: round-robin on ties, word-aligned address,
  // abort after TMO stalls with zeroed read data.
  function automatic vec_t gen(input logic force_tie);
    vec_t v;
    v.fr = force_tie | 1'($urandom_range(0, 1));
    v.dr = force_tie | 1'($urandom_range(0, 1));
    if (!v.fr && !v.dr) v.dr = 1'b1;
    v.dw = 1'($urandom_range(0, 1));
    v.fa = $urandom; v.da = $urandom;
    v.be = 4'($urandom_range(1, 15));
    v.wd = $urandom; v.rd = $urandom;
    v.waits = $urandom_range(0, 6);
    v.exp_fetch = (v.fr && v.dr) ? !m_last_fetch : v.fr;
    v.exp_addr  = (v.exp_fetch ? v.fa : v.da) & 32'hFFFF_FFFC;
    v.exp_rd    = v.exp_fetch ? 1'b1 : !v.dw;
    v.exp_wr    = !v.exp_fetch && v.dw;
    v.exp_be    = v.exp_fetch ? 4'hF : v.be;
    v.exp_wd    = v.exp_fetch ? 32'h0 : v.wd;
    v.exp_err   = (v.waits >= TMO);
    v.exp_rdata = v.exp_err ? 32'h0 : (v.exp_rd ? v.rd : m_rdata);
    return v;
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    vec_t v;
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h1000, 32'h2002, 4'h3, 32'hDEADBEEF, 32'h11111111, 0,
               1'b1, 32'h1000, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0, 32'h11111111};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 32'h1000, 32'h2002, 4'h3, 32'hDEADBEEF, 32'h22222222, 1,
               1'b0, 32'h2000, 1'b1, 1'b0, 4'h3, 32'hDEADBEEF, 1'b0, 32'h22222222};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h1004, 32'h3001, 4'hC, 32'hCAFEF00D, 32'h33333333, 2,
               1'b1, 32'h1004, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0, 32'h33333333};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h1004, 32'h3001, 4'hC, 32'hCAFEF00D, 32'h44444444, 2,
               1'b0, 32'h3000, 1'b0, 1'b1, 4'hC, 32'hCAFEF00D, 1'b0, 32'h33333333};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 32'hBFC00003, 32'h0, 4'h0, 32'h0, 32'h12345678, 0,
               1'b1, 32'hBFC00000, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0, 32'h12345678};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h100, 4'h4, 32'h00AB0000, 32'h55555555, 3,
               1'b0, 32'h100, 1'b0, 1'b1, 4'h4, 32'h00AB0000, 1'b0, 32'h12345678};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h204, 4'hF, 32'h0, 32'h66666666, 9,
               1'b0, 32'h204, 1'b1, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h43, 32'h0, 4'h0, 32'h0, 32'h77777777, 1,
               1'b1, 32'h40, 1'b1, 1'b0, 4'hF, 32'h0, 1'b0, 32'h77777777};

    reset = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_write = 1'b0;
    fetch_addr = '0; data_addr = '0; data_byteenable = '0; data_writedata = '0;
    readdata = '0; waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_strobes", read | write, 1'b0);
    chk1("rst_acks", fetch_ack | data_ack | err, 1'b0);
    chk32("rst_address", address, 32'h0);
    chk32("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_last_fetch = 1'b0;
    m_rdata      = '0;

    for (int i = 0; i < 8; i++) run(tbl[i]);
    repeat (3) chk_idle("after_drop");

    // Reset lands while a fetch is stalled on the bus.
    fetch_req = 1'b1; fetch_addr = 32'h0000_0800;
    @(posedge clk); #1;
    waitrequest = 1'b1; reset = 1'b1;
    @(negedge clk);
    chk1("pre_rst_read", read, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0; fetch_req = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    chk1("midrst_busy", busy, 1'b0);
    chk1("midrst_strobes", read | write, 1'b0);
    chk1("midrst_acks", fetch_ack | data_ack | err, 1'b0);
    chk32("midrst_address", address, 32'h0);
    chk32("midrst_be_wd", {28'd0, byteenable} | writedata, 32'h0);
    chk32("midrst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    m_last_fetch = 1'b0;
    m_rdata      = '0;
    repeat (2) chk_idle("post_rst");
    v = gen(1'b1);
    chk1("tie_after_reset_model", v.exp_fetch, 1'b1);
    run(v);

    for (int i = 0; i < 40; i++) begin
      v = gen(1'b0);
      run(v);
      repeat ($urandom_range(0, 2)) chk_idle("gap");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
